tdm_demux_1xn: RTL
==================

// Module: tdm_demux_1xn
// PURPOSE
//  Time-division demultiplexer: receives a single word-serial stream carrying NUM_CH
//  interleaved channel samples per frame (slot 0 flagged by frame_sync) and distributes
//  each word to its channel. Completed frames are presented atomically on a
//  double-buffered parallel output. Receive-side counterpart of the channel-select
//  muxing used on the transmit side; sits between the serial link and per-channel logic.
// PARAMETERS
//  NUM_CH   4  channels (slots) per frame, >=2
//  DATA_W   8  bits per channel sample
// PORTS
//  clk          in   1              rising-edge clock, single domain
//  rst          in   1              synchronous, active-high reset
//  din          in   DATA_W         serial sample word
//  din_valid    in   1              din valid this cycle (no backpressure)
//  frame_sync   in   1              qualifies din as slot 0; ignored when din_valid=0
//  frame_data   out  NUM_CH*DATA_W  last complete frame; ch k at [k*DATA_W +: DATA_W]
//  frame_valid  out  1              1-cycle pulse: frame_data just updated
//  slot         out  clog2(NUM_CH)  slot index the next accepted word will occupy
//  locked       out  1              1 = in ACTIVE state
//  sync_err     out  1              1-cycle pulse: framing violation detected
// BEHAVIOUR
//  Reset: frame_data=0, frame_valid=0, slot=0, locked=0, sync_err=0, work buffer=0, state=HUNT.
//  Accepted word = din_valid=1 on a clock edge. Cycles with din_valid=0 change nothing.
//  FSM (2 states):
//   HUNT: word without frame_sync -> dropped, no error. Word with frame_sync -> store in
//     work[0], slot<=1, ->ACTIVE.
//   ACTIVE: word with frame_sync=0 and slot!=0 -> work[slot]<=din, slot++.
//     Word with frame_sync=1 and slot!=0 (early sync) -> sync_err pulse, partial frame
//     discarded (no frame_valid), din stored in work[0], slot<=1, stay ACTIVE.
//     Word at slot==0 with frame_sync=1 -> normal next frame: work[0]<=din, slot<=1.
//     Word at slot==0 with frame_sync=0 (missing sync) -> sync_err pulse, word dropped,
//     ->HUNT, slot stays 0.
//  Frame completion: accepting slot NUM_CH-1 -> next edge frame_data<={din,work[NUM_CH-2:0]}
//   in one update (never a mixed frame), frame_valid=1 for exactly that cycle, slot wraps to 0.
//  Latency: last word of frame at edge N -> frame_data/frame_valid visible after edge N.
//  frame_data holds between completions; unaffected by errors or HUNT.
//  sync_err and frame_valid never assert in the same cycle.
//  NUM_CH non-power-of-2: slot counts 0..NUM_CH-1 and wraps explicitly.
//  rst mid-frame: partial work discarded, all outputs to reset values next edge.
//  Back-to-back frames at din_valid=1 every cycle sustain one frame per NUM_CH cycles.
// TESTING (NUM_CH=4, DATA_W=8)
//  T1 after rst, din 11,22,33,44 valid every cycle, sync on 11 -> one cycle after 44:
//     frame_data=32'h44332211, frame_valid=1 for 1 cycle, locked=1, slot=0.
//  T2 words AA,BB without sync in HUNT, then T1 frame -> AA/BB dropped, no sync_err,
//     frame_data=32'h44332211.
//  T3 sync+01,02, sync+03,04,05,06 -> sync_err pulse when 03 accepted; frame_data=32'h06050403,
//     no frame_valid for the 01/02 partial.
//  T4 full frame then next word 77 with frame_sync=0 -> sync_err 1 cycle, locked=0,
//     frame_data unchanged.
//  T5 frame with din_valid gaps (valid 1,0,0,1,0,1,1) -> same frame_data as gap-free, slot
//     holds across gaps.
//  T6 rst asserted after 2 words of a frame -> all outputs 0, locked=0; following sync
//     frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux_1xn.sv
// tdm_demux_1xn: splits a word-serial TDM stream into channels and presents each
// completed frame atomically on a double-buffered parallel output.
module tdm_demux_1xn #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          din,
    input  logic                       din_valid,
    input  logic                       frame_sync,
    output logic [NUM_CH*DATA_W-1:0]   frame_data,
    output logic                       frame_valid,
    output logic [$clog2(NUM_CH)-1:0]  slot,
    output logic                       locked,
    output logic                       sync_err
);
    localparam int SW = $clog2(NUM_CH);
    localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

    typedef enum logic {HUNT, ACTIVE} state_t;
    state_t state;
    // slots 0..NUM_CH-2 are staged here; the final slot goes straight to frame_data
    logic [(NUM_CH-1)*DATA_W-1:0] work;

    assign locked = state == ACTIVE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            work        <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            slot        <= '0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                if (state == HUNT) begin
                    if (frame_sync) begin
                        work[DATA_W-1:0] <= din;
                        slot             <= SW'(1);
                        state            <= ACTIVE;
                    end
                end else if (frame_sync) begin
                    sync_err         <= slot != '0;
                    work[DATA_W-1:0] <= din;
                    slot             <= SW'(1);
                end else if (slot == '0) begin
                    sync_err <= 1'b1;
                    state    <= HUNT;
                end else if (slot == LAST) begin
                    frame_data  <= {din, work};
                    frame_valid <= 1'b1;
                    slot        <= '0;
                end else begin
                    work[slot*DATA_W +: DATA_W] <= din;
                    slot                        <= slot + SW'(1);
                end
            end
        end
    end
endmodule
